// File: rtl/hex_keypad_reader.sv
// Hex keypad reader: scans a 4x4 active-low keypad, debounces presses and
// releases, and packs eight hex digits into a 32-bit word for a consumer.
module hex_keypad_reader #(
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scan_tick,
   input  logic [3:0]  col,
   input  logic        clr,
   input  logic        word_ack,
   output logic [3:0]  row,
   output logic [31:0] entry,
   output logic [3:0]  digits,
   output logic        word_valid
);

   localparam logic [1:0] SCAN    = 2'd0;
   localparam logic [1:0] CONFIRM = 2'd1;
   localparam logic [1:0] HELD    = 2'd2;
   localparam logic [1:0] FULL    = 2'd3;
   localparam logic [3:0] DB      = 4'(DEBOUNCE);

   logic [3:0] col_meta;
   logic [3:0] col_s;
   logic [1:0] state;
   logic [1:0] r;
   logic [1:0] c;
   logic [3:0] key;
   logic [3:0] press_cnt;
   logic [3:0] rel_cnt;
   logic [1:0] low_col;
   logic       any_low;
   logic       accept;
   logic [3:0] new_key;
   logic       flush;

   function automatic logic [1:0] lowest_low(input logic [3:0] v);
      if (!v[0])      return 2'd0;
      else if (!v[1]) return 2'd1;
      else if (!v[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_meta <= 4'hF;
         col_s    <= 4'hF;
      end else begin
         col_meta <= col;
         col_s    <= col_meta;
      end
   end

   always_comb begin
      any_low = (col_s != 4'hF);
      low_col = lowest_low(col_s);
      new_key = (state == SCAN) ? {r, low_col} : key;
      flush   = clr | (word_ack & (state == FULL));
      accept  = 1'b0;
      // A debounce of one accepts on the very tick that first sees the press.
      if (scan_tick) begin
         if (state == SCAN)
            accept = any_low && (DB == 4'd1);
         else if (state == CONFIRM)
            accept = !col_s[c] && ((press_cnt + 4'd1) == DB);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SCAN;
         r         <= 2'd0;
         c         <= 2'd0;
         key       <= 4'd0;
         press_cnt <= 4'd0;
         rel_cnt   <= 4'd0;
         entry     <= 32'h0;
         digits    <= 4'd0;
      end else if (flush) begin
         state     <= SCAN;
         r         <= 2'd0;
         c         <= 2'd0;
         key       <= 4'd0;
         press_cnt <= 4'd0;
         rel_cnt   <= 4'd0;
         entry     <= 32'h0;
         digits    <= 4'd0;
      end else begin
         if (accept) begin
            entry  <= {entry[27:0], new_key};
            digits <= digits + 4'd1;
         end
         if (scan_tick) begin
            case (state)
               SCAN: begin
                  if (!any_low) begin
                     r <= r + 2'd1;
                  end else begin
                     c         <= low_col;
                     key       <= {r, low_col};
                     press_cnt <= 4'd1;
                     rel_cnt   <= 4'd0;
                     state     <= accept ? HELD : CONFIRM;
                  end
               end
               CONFIRM: begin
                  if (col_s[c]) begin
                     r         <= r + 2'd1;
                     press_cnt <= 4'd0;
                     state     <= SCAN;
                  end else begin
                     press_cnt <= press_cnt + 4'd1;
                     if (accept) begin
                        rel_cnt <= 4'd0;
                        state   <= HELD;
                     end
                  end
               end
               HELD: begin
                  if (col_s == 4'hF) begin
                     if ((rel_cnt + 4'd1) == DB) begin
                        r       <= r + 2'd1;
                        rel_cnt <= 4'd0;
                        state   <= (digits == 4'd8) ? FULL : SCAN;
                     end else begin
                        rel_cnt <= rel_cnt + 4'd1;
                     end
                  end else begin
                     rel_cnt <= 4'd0;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign row        = (state == FULL) ? 4'hF : ~(4'b0001 << r);
   assign word_valid = (state == FULL);

endmodule

// File: tb/tb_hex_keypad_reader.sv
// Bench for hex_keypad_reader: a keypad matrix model answers the row drive,
// and a digit-queue reference predicts entry, digits and word_valid.
module tb_hex_keypad_reader;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        scan_tick;
   logic [3:0]  col;
   logic        clr;
   logic        word_ack;
   logic [3:0]  row;
   logic [31:0] entry;
   logic [3:0]  digits;
   logic        word_valid;

   logic [15:0] pressed;
   int          n_vec = 0;
   int          n_err = 0;
   int unsigned digq[$];

   hex_keypad_reader #(.DEBOUNCE(D)) dut (
      .clk(clk), .reset(reset), .scan_tick(scan_tick), .col(col), .clr(clr),
      .word_ack(word_ack), .row(row), .entry(entry), .digits(digits),
      .word_valid(word_valid)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col = 4'hF;
      for (int rr = 0; rr < 4; rr++)
         if (!row[rr])
            for (int cc = 0; cc < 4; cc++)
               if (pressed[rr*4+cc]) col[cc] = 1'b0;
   end

   function automatic logic [31:0] model_entry();
      logic [31:0] acc = 32'h0;
      foreach (digq[i]) acc = acc * 16 + digq[i];
      return acc;
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         @(negedge clk);
         scan_tick = 1'b1;
         @(negedge clk);
         scan_tick = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; scan_tick = 1'b0; clr = 1'b0; word_ack = 1'b0; pressed = 16'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      digq.delete();
   endtask

   task automatic press(input logic [15:0] mask);
      pressed = mask;
      tick(12);
      pressed = 16'h0;
      tick(8);
   endtask

   task automatic pulse_ack();
      word_ack = 1'b1;
      @(negedge clk);
      word_ack = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (row !== 4'b1110) begin n_err++; $display("FAIL reset_row: got %b want 1110", row); end
      n_vec++; if (entry !== 32'h0) begin n_err++; $display("FAIL reset_entry: got %h want 0", entry); end
      n_vec++; if (digits !== 4'd0) begin n_err++; $display("FAIL reset_digits: got %0d want 0", digits); end
      n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", word_valid); end
   endtask

   task automatic test_scan_rotation();
      logic [3:0] exp_row;
      logic [3:0] one = 4'b0001;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick(1);
         exp_row = ~(one << ((i + 1) % 4));
         n_vec++; if (row !== exp_row) begin n_err++; $display("FAIL scan_row[%0d]: got %b want %b", i, row, exp_row); end
      end
      n_vec++; if (entry !== 32'h0 || word_valid !== 1'b0) begin
         n_err++; $display("FAIL scan_idle: got entry %h valid %b want 0 0", entry, word_valid);
      end
   endtask

   task automatic test_single_key();
      do_reset();
      pressed = 16'h1 << 9;
      tick(6);
      n_vec++; if (entry !== 32'h9) begin n_err++; $display("FAIL key9_entry: got %h want 9", entry); end
      n_vec++; if (digits !== 4'd1) begin n_err++; $display("FAIL key9_digits: got %0d want 1", digits); end
      pressed = 16'h0;
      tick(4);
      n_vec++; if (row !== 4'b0111) begin n_err++; $display("FAIL key9_resume_row: got %b want 0111", row); end
      n_vec++; if (entry !== 32'h9) begin n_err++; $display("FAIL key9_hold_entry: got %h want 9", entry); end
   endtask

   task automatic test_bounce();
      do_reset();
      pressed = 16'h1 << 9;
      tick(4);
      pressed = 16'h0;
      tick(1);
      n_vec++; if (digits !== 4'd0 || entry !== 32'h0) begin
         n_err++; $display("FAIL bounce_capture: got digits %0d entry %h want 0 0", digits, entry);
      end
      n_vec++; if (row !== 4'b0111) begin n_err++; $display("FAIL bounce_row: got %b want 0111", row); end
      tick(1);
      n_vec++; if (row !== 4'b1110) begin n_err++; $display("FAIL bounce_next_row: got %b want 1110", row); end
   endtask

   task automatic test_full_word();
      do_reset();
      for (int k = 1; k <= 8; k++) press(16'h1 << k);
      n_vec++; if (entry !== 32'h12345678) begin n_err++; $display("FAIL full_entry: got %h want 12345678", entry); end
      n_vec++; if (word_valid !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", word_valid); end
      n_vec++; if (row !== 4'b1111) begin n_err++; $display("FAIL full_row: got %b want 1111", row); end
      press(16'h1 << 10);
      n_vec++; if (entry !== 32'h12345678 || digits !== 4'd8) begin
         n_err++; $display("FAIL full_blocked: got entry %h digits %0d want 12345678 8", entry, digits);
      end
   endtask

   task automatic test_ack();
      pulse_ack();
      n_vec++; if (word_valid !== 1'b0) begin n_err++; $display("FAIL ack_valid: got %b want 0", word_valid); end
      n_vec++; if (entry !== 32'h0 || digits !== 4'd0) begin
         n_err++; $display("FAIL ack_clear: got entry %h digits %0d want 0 0", entry, digits);
      end
      n_vec++; if (row !== 4'b1110) begin n_err++; $display("FAIL ack_row: got %b want 1110", row); end
      press(16'h1 << 15);
      n_vec++; if (entry !== 32'hF) begin n_err++; $display("FAIL ack_keyF: got %h want F", entry); end
      pulse_ack();
      n_vec++; if (entry !== 32'hF || digits !== 4'd1) begin
         n_err++; $display("FAIL ack_ignored: got entry %h digits %0d want F 1", entry, digits);
      end
   endtask

   task automatic test_clr_and_midreset();
      do_reset();
      for (int i = 0; i < 3; i++) press(16'h1 << $urandom_range(0, 15));
      pressed = 16'hFFFF;
      @(negedge clk);
      @(negedge clk);
      scan_tick = 1'b1; clr = 1'b1;
      @(negedge clk);
      scan_tick = 1'b0; clr = 1'b0; pressed = 16'h0;
      n_vec++; if (entry !== 32'h0 || digits !== 4'd0) begin
         n_err++; $display("FAIL clr_clear: got entry %h digits %0d want 0 0", entry, digits);
      end
      n_vec++; if (row !== 4'b1110) begin n_err++; $display("FAIL clr_row: got %b want 1110", row); end
      tick(6);
      n_vec++; if (digits !== 4'd0) begin n_err++; $display("FAIL clr_no_capture: got %0d want 0", digits); end
      press(16'h1 << 5);
      pressed = 16'hFFFF;
      tick(2);
      #2 reset = 1'b1;
      #1;
      n_vec++; if (row !== 4'b1110 || entry !== 32'h0 || digits !== 4'd0 || word_valid !== 1'b0) begin
         n_err++; $display("FAIL midreset_async: got row %b entry %h digits %0d valid %b want 1110 0 0 0", row, entry, digits, word_valid);
      end
      pressed = 16'h0;
      @(negedge clk);
      reset = 1'b0;
      tick(3);
      n_vec++; if (entry !== 32'h0 || digits !== 4'd0) begin
         n_err++; $display("FAIL midreset_after: got entry %h digits %0d want 0 0", entry, digits);
      end
   endtask

   task automatic test_random();
      int          act, rr, cmask, lc, h;
      logic [15:0] mask;
      do_reset();
      for (int it = 0; it < 40; it++) begin
         act = $urandom_range(0, 9);
         if (act <= 5) begin
            rr    = $urandom_range(0, 3);
            cmask = (act == 5) ? $urandom_range(1, 15) : (1 << $urandom_range(0, 3));
            lc = 0;
            while (((cmask >> lc) & 1) == 0) lc++;
            mask = 16'(cmask) << (rr * 4);
            press(mask);
            if (digq.size() < 8) digq.push_back(rr * 4 + lc);
         end else if (act <= 7) begin
            h = $urandom_range(1, D - 1);
            pressed = 16'h1 << $urandom_range(0, 15);
            tick(h);
            pressed = 16'h0;
            tick(D + 2);
         end else if (act == 8) begin
            pulse_ack();
            if (digq.size() == 8) digq.delete();
         end else begin
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            digq.delete();
         end
         n_vec++; if (entry !== model_entry()) begin
            n_err++; $display("FAIL rand_entry[%0d]: got %h want %h", it, entry, model_entry());
         end
         n_vec++; if (digits !== 4'(digq.size())) begin
            n_err++; $display("FAIL rand_digits[%0d]: got %0d want %0d", it, digits, digq.size());
         end
         n_vec++; if (word_valid !== (digq.size() == 8)) begin
            n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", it, word_valid, digq.size() == 8);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_rotation();
      test_single_key();
      test_bounce();
      test_full_word();
      test_ack();
      test_clr_and_midreset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hex_keypad_reader.md
HEX_KEYPAD_READER -- requirements
Module: hex_keypad_reader

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 4, number of consecutive scan_tick samples required to accept a press or a release (legal range 1..15).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port scan_tick  input  1  single-cycle scan strobe; logic advances only on cycles where it is high.
REQ-005 SHALL have port col  input  4  raw keypad column lines, active-low, asynchronous to clk.
REQ-006 SHALL have port clr  input  1  synchronous abort of the current entry.
REQ-007 SHALL have port word_ack  input  1  consumer acknowledge of the completed word.
REQ-008 SHALL have port row  output  4  keypad row drive, active-low one-hot.
REQ-009 SHALL have port entry  output  32  word being assembled, most recent digit in [3:0].
REQ-010 SHALL have port digits  output  4  number of digits captured, 0..8.
REQ-011 SHALL have port word_valid  output  1  high while a completed 8-digit word is held in entry.

Function
REQ-012 SHALL pass col through a two-flop synchronizer on clk; all decisions use the synchronized value colS.
REQ-013 SHALL keep a 2-bit row index r; row = ~(4'b0001 << r) in SCAN, CONFIRM and HELD; row = 4'b1111 in FULL.
REQ-014 SHALL implement states SCAN, CONFIRM, HELD, FULL; a state or counter changes only on scan_tick cycles, except for clr, word_ack and reset.
REQ-015 SCAN, on scan_tick with colS == 4'b1111: r increments mod 4 and the state stays SCAN.
REQ-016 SCAN, on scan_tick with any colS bit low: c = lowest-index low bit; key = {r,c} is latched; debounce count = 1; r is frozen; next state CONFIRM.
REQ-017 CONFIRM, on scan_tick with colS[c] low: count increments.
REQ-018 CONFIRM, when count reaches DEBOUNCE: entry <= {entry[27:0], key}; digits increments; next state HELD with release count = 0.
REQ-019 CONFIRM, on scan_tick with colS[c] high: the press is discarded, r increments mod 4, and the next state is SCAN.
REQ-020 With DEBOUNCE == 1, acceptance SHALL occur on the same scan_tick that enters CONFIRM, so that tick goes directly to HELD.
REQ-021 HELD, on scan_tick with colS == 4'b1111: release count increments; any low bit resets it to 0.
REQ-022 HELD, when release count reaches DEBOUNCE: r increments mod 4; next state is SCAN, or FULL if digits == 8.
REQ-023 The key code SHALL be r*4 + c, covering hex 0..F; there is no other key-to-value mapping.
REQ-024 FULL: word_valid = 1; the keypad is ignored; entry and digits are held.
REQ-025 On word_ack while word_valid: next cycle word_valid = 0, entry = 0, digits = 0, r = 0, state = SCAN.
REQ-026 word_ack while word_valid is low SHALL be ignored.
REQ-027 clr in any state SHALL give the same next-cycle result as REQ-025; clr and word_ack together behave as clr.
REQ-028 clr or word_ack SHALL take priority over a coincident scan_tick.
REQ-029 digits SHALL never exceed 8; a 9th digit cannot be captured because FULL blocks scanning.
REQ-030 Multiple simultaneous column presses SHALL resolve to the lowest column index only.

Reset
REQ-031 On reset: state = SCAN, r = 0, row = 4'b1110, entry = 32'h0, digits = 0, word_valid = 0, all counters = 0, synchronizer flops = 4'b1111.
REQ-032 Reset asserted mid-entry or in FULL SHALL discard all partial data with no output glitch beyond the reset values.

Verification
REQ-033 Reset, no keys, 8 scan_ticks: row sequence 1110, 1101, 1011, 0111, 1110, ...; entry = 0; word_valid = 0.
REQ-034 DEBOUNCE = 4; press row 2 col 1 held 4 ticks, then release for 4 ticks: entry = 32'h9, digits = 1, row resumes at 0111.
REQ-035 Press held only 2 ticks (bounce): no capture, digits = 0, scanning resumes at the next row.
REQ-036 Enter keys 1,2,3,4,5,6,7,8: entry = 32'h12345678, word_valid = 1, row = 4'b1111; a further press leaves entry unchanged.
REQ-037 From FULL, pulse word_ack for 1 cycle: next cycle word_valid = 0, entry = 0, digits = 0; then press F (r3,c3): entry = 32'hF.
REQ-038 After 3 digits, assert clr together with scan_tick and a pressed key: entry = 0, digits = 0, no capture; reset asserted mid-CONFIRM returns all outputs to REQ-031 values.
